aes_inv_key_schedule: RTL and testbench

Sequential reverse-order AES-128 key scheduler for the decryption datapath. It is loaded with the final round key, round 10, and regenerates round keys 10 down to 0 on the fly, one per accepted transfer. This means the decryption core never has to store the full 11-key expansion. It is the counterpart of the forward combinational key expansion and sits between the key register and the inverse-cipher round engine.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes_inv_key_schedule.sv | 108 ++++++++++
 tb/tb_aes_inv_key_schedule.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and word-level helpers for the key expansion and its reverse.
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_key_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_FIN  = 2'd2
    } ks_state_t;

    localparam logic [7:0] RCON_LAST = 8'h36;

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Inverse of xtime: steps Rcon[r] back to Rcon[r-1].
    function automatic logic [7:0] rcon_prev(input logic [7:0] r);
        return (r >> 1) ^ (r[0] ? 8'h8d : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Entry 0 sits in the top byte, so the lookup offset is (255 - data_i) * 8.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] offset_s;

    assign offset_s = {~data_i, 3'b000};
    assign data_o   = SBOX_TABLE[offset_s +: 8];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Reverse-order AES-128 key scheduler: loaded with the round-10 key, it
// regenerates round keys 10 down to 0, one per accepted valid/ready handshake.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    ks_state_t  state_q;
    logic       rk_valid_q;
    aes_key_t   rk_data_q;
    logic [3:0] rk_round_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] rcon_q;

    aes_word_t  k0_s, k1_s, k2_s, k3_s;
    aes_word_t  p3_s, rot_s, sub_s;
    aes_key_t   prev_key_d;

    assign {k0_s, k1_s, k2_s, k3_s} = rk_data_q;
    assign p3_s  = k3_s ^ k2_s;
    assign rot_s = rot_word(p3_s);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .data_i (rot_s[8*i +: 8]),
            .data_o (sub_s[8*i +: 8])
        );
    end

    // w0 of the previous round needs SubWord of the recovered previous w3 (= k3 ^ k2).
    assign prev_key_d = {k0_s ^ sub_s ^ {rcon_q, 24'h000000},
                         k1_s ^ k0_s,
                         k2_s ^ k1_s,
                         p3_s};

    // Schedule FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rk_valid_q <= 1'b0;
            rk_data_q  <= 128'h0;
            rk_round_q <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rcon_q     <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        rk_data_q  <= last_key;
                        rk_round_q <= LAST_ROUND;
                        rcon_q     <= RCON_LAST;
                        rk_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_valid_q && rk_ready) begin
                        if (rk_round_q != 4'd0) begin
                            rk_data_q  <= prev_key_d;
                            rk_round_q <= rk_round_q - 4'd1;
                            rcon_q     <= rcon_prev(rcon_q);
                        end else begin
                            rk_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    rk_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_round = rk_round_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench: table vectors plus random keys, checked against a
// forward AES-128 key expansion model built from GF(2^8) arithmetic.
module tb_aes_inv_key_schedule;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] last_key;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_m [0:255];
    logic [127:0] model_rk [0:10];
    logic [127:0] got_keys [0:10];

    typedef struct {
        logic [127:0] last_key;
        logic [127:0] exp_r0;
        int           stall_pct;
        bit           spam;
    } vec_t;

    vec_t vecs [4];

    aes_inv_key_schedule #(.ROUNDS(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .last_key (last_key),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Standard forward expansion; round key r = w[4r..4r+3].
    task automatic expand(input logic [127:0] key0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic run_schedule(input logic [127:0] lk, input int stall_pct, input bit spam);
        int           exp_round;
        int           cyc;
        bit           stalled;
        bit           abort;
        logic [127:0] held;
        for (int r = 0; r < 11; r++) got_keys[r] = 128'h0;
        @(negedge clk);
        start = 1'b1; last_key = lk; rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        exp_round = 10; cyc = 1; stalled = 1'b0; abort = 1'b0; held = 128'h0;
        while (exp_round >= 0 && cyc < 400 && !abort) begin
            if (!rk_valid) begin
                check_eq("valid_during_emit", 128'(rk_valid), 128'd1);
                abort = 1'b1;
            end else begin
                check_eq("round_index", 128'(rk_round), 128'(exp_round));
                check_eq("busy_during_emit", 128'(busy), 128'd1);
                if (stalled) check_eq("stall_hold", rk_data, held);
                rk_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
                if (spam) begin
                    start = $urandom_range(0, 1) == 1;
                    last_key = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
                if (rk_ready) begin
                    got_keys[exp_round] = rk_data;
                    exp_round--;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = rk_data;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (exp_round >= 0 && !abort) check_eq("schedule_timeout", 128'(exp_round), 128'h0 - 128'd1);
        // Done cycle: done high, busy still high, valid low.
        check_eq("done_pulse", 128'(done), 128'd1);
        check_eq("busy_in_done", 128'(busy), 128'd1);
        check_eq("valid_in_done", 128'(rk_valid), 128'd0);
        if (stall_pct == 0) check_eq("done_cycle", 128'(cyc), 128'd12);
        start = spam;
        last_key = {$urandom(), $urandom(), $urandom(), $urandom()};
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("done_single", 128'(done), 128'd0);
        check_eq("busy_after", 128'(busy), 128'd0);
        check_eq("valid_after", 128'(rk_valid), 128'd0);
    endtask

    task automatic compare_all(input string tag);
        for (int r = 0; r < 11; r++)
            check_eq($sformatf("%s_rk%0d", tag, r), got_keys[r], model_rk[r]);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; last_key = 128'h0;
        build_sbox();
        vecs[0] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0};
        vecs[1] = '{128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h000102030405060708090a0b0c0d0e0f, 0, 1'b0};
        vecs[2] = '{128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'h0, 50, 1'b0};
        vecs[3] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b1};

        #12;
        check_eq("reset_valid", 128'(rk_valid), 128'd0);
        check_eq("reset_data", rk_data, 128'h0);
        check_eq("reset_round", 128'(rk_round), 128'd0);
        check_eq("reset_busy", 128'(busy), 128'd0);
        check_eq("reset_done", 128'(done), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            expand(vecs[v].exp_r0);
            run_schedule(vecs[v].last_key, vecs[v].stall_pct, vecs[v].spam);
            check_eq($sformatf("vec%0d_r10", v), got_keys[10], vecs[v].last_key);
            check_eq($sformatf("vec%0d_r0", v), got_keys[0], vecs[v].exp_r0);
            compare_all($sformatf("vec%0d", v));
            if (v == 0) begin
                check_eq("fips_r9", got_keys[9], 128'hac7766f319fadc2128d12941575c006e);
                check_eq("fips_r1", got_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
            end
        end

        // Reset in the middle of a schedule.
        @(negedge clk);
        start = 1'b1; last_key = vecs[0].last_key; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(rk_valid && rk_round == 4'd5) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reach_round5", 128'(rk_round), 128'd5);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 128'(rk_valid), 128'd0);
        check_eq("midrst_data", rk_data, 128'h0);
        check_eq("midrst_round", 128'(rk_round), 128'd0);
        check_eq("midrst_busy", 128'(busy), 128'd0);
        check_eq("midrst_done", 128'(done), 128'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_no_done", 128'(done), 128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_idle", 128'(busy), 128'd0);
        expand(vecs[0].exp_r0);
        run_schedule(vecs[0].last_key, 0, 1'b0);
        compare_all("post_rst");

        // Random keys through the forward model, alternating stall patterns.
        for (int k = 0; k < 6; k++) begin
            logic [127:0] key0;
            key0 = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand(key0);
            run_schedule(model_rk[10], (k % 2 == 0) ? 0 : 40, k == 5);
            compare_all($sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
